triplet_loss_sequencer: RTL
===========================

# triplet_loss_sequencer

- Control and accumulate engine for the Triplet Margin Loss operator.
- Takes a batch of (anchor, positive, negative) vector triplets as an element stream and accumulates both squared L2 distances per sample.
- Shares one external square-root unit through a req/ack handshake, applies the margin hinge, and reports the batch-mean loss.
- Sits between the tensor fetch logic and the shared sqrt resource.

## Interface
Parameters:
- DATA_W, 16: element width, signed Q8.8; margin is unsigned Q8.8.
- DIM, 8: elements per vector. Must be ≥1.
- BATCH, 4: triplets per run. Power of two, ≥1.
- ACC_W, 40: distance accumulator width. Even number, ≥2*DATA_W+2.
- LOSS_W, ACC_W/2+$clog2(BATCH)+2: width of loss_out.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request. Sampled only in IDLE.
- margin  in  DATA_W  hinge margin. Captured on the accepted start.
- elem_valid  in  1  element triplet present.
- elem_ready  out  1  sequencer accepts an element.
- anchor, positive, negative  in  DATA_W each  one element of each vector.
- sqrt_req  out  1  square-root request.
- sqrt_radicand  out  ACC_W  unsigned Q(ACC_W-32).32 value. Held stable while sqrt_req=1.
- sqrt_ack  in  1  root valid.
- sqrt_root  in  ACC_W/2  unsigned Q.16 root.
- busy  out  1  run in progress.
- loss_valid  out  1  one-cycle pulse marking a valid loss_out.
- loss_out  out  LOSS_W  unsigned loss. Q.8 for the mean; see Configuration.

## Operation
FSM states: IDLE, STREAM, SQRT_AP, SQRT_AN, COMBINE, OUTPUT.

- IDLE
  - start=1 → STREAM. Also captures margin and clears acc_ap, acc_an, elem_cnt, samp_cnt and batch_sum.
- STREAM
  - elem_ready=1 in this state only.
  - On each elem_valid&&elem_ready:
    - dap=anchor−positive and dan=anchor−negative, each DATA_W+1 signed.
    - Squares are unsigned, 2*DATA_W+2 bits.
    - Each square is added to its accumulator. Addition saturates at 2^ACC_W−1.
  - Accepting element DIM−1 → SQRT_AP.
- SQRT_AP
  - sqrt_req=1, sqrt_radicand=acc_ap.
  - On sqrt_ack: capture r_ap=sqrt_root → SQRT_AN.
  - sqrt_ack may arrive in the same cycle sqrt_req rises.
- SQRT_AN
  - Same as SQRT_AP, using acc_an; capture r_an → COMBINE.
- COMBINE (1 cycle)
  - t = r_ap − r_an + (margin<<8), computed signed in ACC_W/2+2 bits. A Q.8 margin aligns to Q.16 by the <<8.
  - loss_i = (t<0) ? 0 : t. Add loss_i to batch_sum.
  - Clear acc_ap, acc_an and elem_cnt.
  - If samp_cnt==BATCH−1 → OUTPUT; else increment samp_cnt → STREAM.
- OUTPUT (1 cycle)
  - loss_valid=1.
  - loss_out = batch_sum >> (8+log2 BATCH). This truncates to a Q.8 mean.
  - Next state IDLE.
- busy=1 in every state except IDLE.

Boundary rules:
- start while busy: ignored; no queuing.
- sqrt_ack while sqrt_req=0: ignored.
- elem_valid outside STREAM: ignored, nothing consumed.
- DIM=1: STREAM lasts exactly one accepted element.
- BATCH=1: the run has no shift; loss_out = batch_sum>>8.
- rst asserted in any state:
  - Immediate return to IDLE. All counters and accumulators cleared.
  - Any partial batch is discarded; no loss_valid is produced for it.

## Timing
- Reset values: elem_ready=0, sqrt_req=0, sqrt_radicand=0, busy=0, loss_valid=0, loss_out=0.
- loss_out holds its value until the next OUTPUT or reset.
- Reference latency assumes elem_valid held at 1 and sqrt_ack returned in the same cycle as the request.
  - start sampled high in cycle 0.
  - loss_valid is high in cycle 1+BATCH*(DIM+3).
  - busy is high for cycles 1 through 1+BATCH*(DIM+3).
- Each cycle elem_valid is low in STREAM adds one cycle of latency.
- Each cycle of sqrt_ack delay adds one cycle of latency.
- All outputs are registered, except elem_ready and sqrt_req, which decode directly from state.

## Configuration
- Macro TRIPLET_LOSS_SUM_REDUCTION_EN.
- Defined: reduction='sum'. OUTPUT presents batch_sum>>8 (Q.8 sum, no division by BATCH).
- Undefined: reduction='mean', as described above.
- FSM and timing are identical in both builds.

## Test plan
1. **Hinge at margin**
   - Stimulus (DIM=8, BATCH=4): every element anchor=positive=negative=0x0100; margin=0x0100. Bench sqrt returns exact floor roots with immediate ack.
   - Required: every radicand=0; loss_out=0x0100; loss_valid in cycle 45.
2. **Hinge clamps to zero**
   - Stimulus: anchor=positive=0, negative=0x0100, margin=0x0100.
   - Required:
     - acc_an radicand = 8<<32.
     - r_an=floor(sqrt(8)·2^16)=0x2D413, so t<0 and loss_i=0.
     - loss_out=0.
3. **Backpressure**
   - Stimulus: vectors as in test 1; elem_valid low every other cycle; sqrt_ack delayed 5 cycles.
   - Required:
     - loss_out=0x0100.
     - sqrt_radicand stable while sqrt_req=1.
     - No element accepted outside STREAM.
     - Total latency = 45+32+40 cycles.
4. **Busy and reset**
   - Stimulus:
     - Pulse start again mid-run: ignored.
     - Then assert rst during STREAM of sample 2.
   - Required:
     - After the reset, all outputs are 0 and busy=0.
     - A fresh run with test-1 data yields loss_out=0x0100 with no stale accumulation.
5. **Saturation**
   - Stimulus: ACC_W=34; anchor=0x7FFF, positive=0x8000 for all 8 elements.
   - Required: sqrt_radicand for the ap distance = 2^34−1.
6. **Sum reduction**
   - Stimulus: build with TRIPLET_LOSS_SUM_REDUCTION_EN; rerun test 1.
   - Required: loss_out=0x0400; loss_valid in cycle 45.

Source files
------------

// File: rtl/triplet_loss_sequencer.sv
// triplet_loss_sequencer: triplet margin loss engine, accumulates ap/an squared distances and shares one sqrt unit
// Ports: clk, rst (async active-high); start, margin (Q8.8, captured on start);
//   elem_valid/elem_ready with anchor/positive/negative (signed Q8.8) element stream;
//   sqrt_req/sqrt_radicand (Q.32) and sqrt_ack/sqrt_root (Q.16) to the shared root unit;
//   busy, loss_valid pulse, loss_out (Q.8).
// Define TRIPLET_LOSS_SUM_REDUCTION_EN to report the Q.8 batch sum instead of the batch mean.
module triplet_loss_sequencer #(
    parameter int DATA_W = 16,
    parameter int DIM = 8,
    parameter int BATCH = 4,
    parameter int ACC_W = 40,
    parameter int LOSS_W = ACC_W/2+$clog2(BATCH)+2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   margin,
    input  logic                elem_valid,
    output logic                elem_ready,
    input  logic [DATA_W-1:0]   anchor,
    input  logic [DATA_W-1:0]   positive,
    input  logic [DATA_W-1:0]   negative,
    output logic                sqrt_req,
    output logic [ACC_W-1:0]    sqrt_radicand,
    input  logic                sqrt_ack,
    input  logic [ACC_W/2-1:0]  sqrt_root,
    output logic                busy,
    output logic                loss_valid,
    output logic [LOSS_W-1:0]   loss_out
);
    localparam int SQ_W = 2*DATA_W+2;
    localparam int SUM_W = (ACC_W > SQ_W+16 ? ACC_W : SQ_W+16) + 1;
    localparam int R_W = ACC_W/2;
    localparam int T_W = R_W+2;
    localparam int CNT_W = DIM > 1 ? $clog2(DIM) : 1;
    localparam int SMP_W = BATCH > 1 ? $clog2(BATCH) : 1;
`ifdef TRIPLET_LOSS_SUM_REDUCTION_EN
    localparam int SH = 8;
`else
    localparam int SH = 8+$clog2(BATCH);
`endif
    typedef enum logic [2:0] {IDLE, STREAM, SQRT_AP, SQRT_AN, COMBINE, OUTPUT} state_t;
    state_t state;
    logic [DATA_W-1:0] margin_q;
    logic [ACC_W-1:0] acc_ap, acc_an, nxt_ap, nxt_an;
    logic [R_W-1:0] r_ap, r_an;
    logic [CNT_W-1:0] elem_cnt;
    logic [SMP_W-1:0] samp_cnt;
    logic [LOSS_W-1:0] batch_sum, sum_nxt;
    logic signed [SQ_W-1:0] dap, dan;
    logic [T_W-1:0] t;

    // Q8.8 squares are Q.16; the <<16 aligns them to the Q.32 radicand format before the saturating add
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc, input logic [SQ_W-1:0] sq);
        logic [SUM_W-1:0] s;
        s = SUM_W'(acc) + (SUM_W'(sq) << 16);
        return s > SUM_W'({ACC_W{1'b1}}) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign dap = SQ_W'($signed(anchor)) - SQ_W'($signed(positive));
    assign dan = SQ_W'($signed(anchor)) - SQ_W'($signed(negative));
    assign nxt_ap = sat_add(acc_ap, dap * dap);
    assign nxt_an = sat_add(acc_an, dan * dan);
    assign t = T_W'(r_ap) - T_W'(r_an) + T_W'({margin_q, 8'h00});
    assign sum_nxt = batch_sum + (t[T_W-1] ? '0 : LOSS_W'(t));
    assign elem_ready = state == STREAM;
    assign sqrt_req = state == SQRT_AP || state == SQRT_AN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            margin_q <= '0;
            acc_ap <= '0;
            acc_an <= '0;
            r_ap <= '0;
            r_an <= '0;
            elem_cnt <= '0;
            samp_cnt <= '0;
            batch_sum <= '0;
            sqrt_radicand <= '0;
            busy <= 1'b0;
            loss_valid <= 1'b0;
            loss_out <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= STREAM;
                    margin_q <= margin;
                    acc_ap <= '0;
                    acc_an <= '0;
                    elem_cnt <= '0;
                    samp_cnt <= '0;
                    batch_sum <= '0;
                    busy <= 1'b1;
                end
                STREAM: if (elem_valid) begin
                    acc_ap <= nxt_ap;
                    acc_an <= nxt_an;
                    elem_cnt <= elem_cnt + CNT_W'(1);
                    if (elem_cnt == CNT_W'(DIM-1)) begin
                        state <= SQRT_AP;
                        sqrt_radicand <= nxt_ap;
                    end
                end
                SQRT_AP: if (sqrt_ack) begin
                    r_ap <= sqrt_root;
                    sqrt_radicand <= acc_an;
                    state <= SQRT_AN;
                end
                SQRT_AN: if (sqrt_ack) begin
                    r_an <= sqrt_root;
                    state <= COMBINE;
                end
                COMBINE: begin
                    batch_sum <= sum_nxt;
                    acc_ap <= '0;
                    acc_an <= '0;
                    elem_cnt <= '0;
                    samp_cnt <= samp_cnt + SMP_W'(1);
                    state <= samp_cnt == SMP_W'(BATCH-1) ? OUTPUT : STREAM;
                    if (samp_cnt == SMP_W'(BATCH-1)) begin
                        loss_valid <= 1'b1;
                        loss_out <= sum_nxt >> SH;
                    end
                end
                OUTPUT: begin
                    loss_valid <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
